// File: rtl/nn_core.sv
// rtl/nn_core.sv - three-layer scalar Q8.8 fixed-point inference datapath
//
// Purpose:
//   Each cycle, the layer selected by `layer` is evaluated:
//     multiply by that layer's weight, drop eight fraction bits (floor),
//     add the bias, saturate to 16 bits, then apply the activation.
//   Layers 0 and 1 use ReLU; layer 2 is linear.
//   The result goes to that layer's stage register and to `out`.
//   Layer 0 reads `in`, layer 1 reads h0 and layer 2 reads h1.
//   Any layer code of 3..7 leaves all state untouched.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset, clears h0..h2 and out
//   layer  in   3   layer to evaluate this cycle (0..2 valid)
//   in     in  16   signed Q8.8 network input, used by layer 0 only
//   out    out 16   signed Q8.8 registered result of last evaluated layer
module nn_core #(
   parameter logic signed [15:0] W0 = 16'sh0200,
   parameter logic signed [15:0] B0 = 16'sh0100,
   parameter logic signed [15:0] W1 = 16'shFF80,
   parameter logic signed [15:0] B1 = 16'sh0400,
   parameter logic signed [15:0] W2 = 16'sh0180,
   parameter logic signed [15:0] B2 = 16'shFF80
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  layer,
   input  logic [15:0] in,
   output logic [15:0] out
);

   localparam logic signed [32:0] SAT_MAX = 33'sd32767;
   localparam logic signed [32:0] SAT_MIN = -33'sd32768;

   logic signed [15:0] h0;
   logic signed [15:0] h1;
   logic signed [15:0] h2;

   logic signed [15:0] x;
   logic signed [15:0] w_sel;
   logic signed [15:0] b_sel;
   logic               relu_en;
   logic               upd;

   logic signed [31:0] prod;
   logic signed [31:0] shifted;
   logic signed [32:0] sum;
   logic signed [15:0] sat;
   logic signed [15:0] result;

   // Operand, coefficient and activation selection for the requested layer.
   always_comb begin
      x       = in;
      w_sel   = W0;
      b_sel   = B0;
      relu_en = 1'b1;
      upd     = 1'b1;
      case (layer)
         3'd0: begin
            x     = in;
            w_sel = W0;
            b_sel = B0;
         end
         3'd1: begin
            x     = h0;
            w_sel = W1;
            b_sel = B1;
         end
         3'd2: begin
            x       = h1;
            w_sel   = W2;
            b_sel   = B2;
            relu_en = 1'b0;
         end
         default: begin
            upd = 1'b0;
         end
      endcase
   end

   // Multiply-add-saturate-activate, all in one cycle.
   always_comb begin
      prod    = x * w_sel;
      // Arithmetic shift floors toward negative infinity; no rounding.
      shifted = prod >>> 8;
      // 33 bits so the bias add can never wrap before saturation.
      sum     = {shifted[31], shifted} + {{17{b_sel[15]}}, b_sel};
      if (sum > SAT_MAX) begin
         sat = 16'sh7FFF;
      end else if (sum < SAT_MIN) begin
         sat = 16'sh8000;
      end else begin
         sat = sum[15:0];
      end
      if (relu_en && sat[15]) begin
         result = 16'sh0000;
      end else begin
         result = sat;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h0  <= 16'sh0000;
         h1  <= 16'sh0000;
         h2  <= 16'sh0000;
         out <= 16'h0000;
      end else if (upd) begin
         out <= result;
         case (layer)
            3'd0:    h0 <= result;
            3'd1:    h1 <= result;
            default: h2 <= result;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_core.sv
// tb/tb_nn_core.sv - self-checking bench for nn_core
module tb_nn_core;

   logic        clk;
   logic        rst_n;
   logic [2:0]  layer;
   logic [15:0] din;
   logic [15:0] out;

   int n_cmp;
   int n_bad;

   nn_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .layer (layer),
      .in    (din),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [2:0]  layer;
      logic [15:0] din;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[$];

   // Reference model: plain integer arithmetic from the layer rules.
   longint wts[3];
   longint bss[3];
   logic [15:0] mh[3];
   logic [15:0] mout;

   function automatic logic [15:0] ref_layer(input int l, input logic [15:0] xin);
      longint xv;
      longint p;
      longint q;
      longint s;
      xv = longint'($signed(xin));
      p  = xv * wts[l];
      if (p >= 0) q = p / 256;
      else        q = -((-p + 255) / 256);
      s = q + bss[l];
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      if (l < 2 && s < 0) s = 0;
      return 16'(s);
   endfunction

   task automatic step(input logic r, input logic [2:0] l, input logic [15:0] d);
      rst_n = r;
      layer = l;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] exp);
      n_cmp++;
      if (out !== exp) begin
         n_bad++;
         $display("FAIL %s: out=%h expected=%h", name, out, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic [2:0] l, input logic [15:0] d);
      logic [15:0] res;
      if (!r) begin
         mh[0] = '0; mh[1] = '0; mh[2] = '0;
         mout  = '0;
      end else if (l < 3) begin
         res = ref_layer(int'(l), (l == 0) ? d : mh[l - 1]);
         mh[l] = res;
         mout  = res;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      wts[0] = 512;  bss[0] = 256;
      wts[1] = -128; bss[1] = 1024;
      wts[2] = 384;  bss[2] = -128;
      rst_n = 1'b0;
      layer = 3'd0;
      din   = 16'h0000;

      // Reset and bias-only layer 1.
      tbl.push_back('{1'b0, 3'd0, 16'h1234, 16'h0000, "reset0"});
      tbl.push_back('{1'b0, 3'd1, 16'h7FFF, 16'h0000, "reset1"});
      tbl.push_back('{1'b1, 3'd1, 16'h5555, 16'h0400, "post_reset_l1"});
      // Nominal chain, each layer held two cycles.
      tbl.push_back('{1'b0, 3'd0, 16'h0000, 16'h0000, "chain_reset"});
      tbl.push_back('{1'b1, 3'd0, 16'h0003, 16'h0106, "chain_l0a"});
      tbl.push_back('{1'b1, 3'd0, 16'h0003, 16'h0106, "chain_l0b"});
      tbl.push_back('{1'b1, 3'd1, 16'h0000, 16'h037D, "chain_l1a"});
      tbl.push_back('{1'b1, 3'd1, 16'h0000, 16'h037D, "chain_l1b"});
      tbl.push_back('{1'b1, 3'd2, 16'h0000, 16'h04BB, "chain_l2a"});
      tbl.push_back('{1'b1, 3'd2, 16'h0000, 16'h04BB, "chain_l2b"});
      // Invalid layer holds out, and h1 is untouched afterwards.
      tbl.push_back('{1'b1, 3'd5, 16'h1111, 16'h04BB, "invalid_a"});
      tbl.push_back('{1'b1, 3'd5, 16'hFF00, 16'h04BB, "invalid_b"});
      tbl.push_back('{1'b1, 3'd5, 16'h7FFF, 16'h04BB, "invalid_c"});
      tbl.push_back('{1'b1, 3'd2, 16'h2222, 16'h04BB, "invalid_then_l2"});
      // ReLU clamp through the chain.
      tbl.push_back('{1'b1, 3'd0, 16'hFF00, 16'h0000, "relu_l0"});
      tbl.push_back('{1'b1, 3'd1, 16'h0000, 16'h0400, "relu_l1"});
      tbl.push_back('{1'b1, 3'd2, 16'h0000, 16'h0580, "relu_l2"});
      // Saturation at both ends.
      tbl.push_back('{1'b1, 3'd0, 16'h7FFF, 16'h7FFF, "sat_pos"});
      tbl.push_back('{1'b1, 3'd0, 16'h8000, 16'h0000, "sat_neg_relu"});
      // Reset mid-operation.
      tbl.push_back('{1'b1, 3'd0, 16'h0003, 16'h0106, "mid_l0"});
      tbl.push_back('{1'b0, 3'd0, 16'h0003, 16'h0000, "mid_reset"});
      tbl.push_back('{1'b1, 3'd1, 16'h0003, 16'h0400, "mid_l1"});

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst_n, tbl[i].layer, tbl[i].din);
         check(tbl[i].name, tbl[i].exp);
      end

      // Hand sequence: invalid layer keeps h0, and in is ignored by layer 1.
      step(1'b1, 3'd0, 16'h0003);
      check("hold_l0", 16'h0106);
      step(1'b1, 3'd7, 16'h7FFF);
      check("hold_inv7", 16'h0106);
      step(1'b1, 3'd1, 16'h7FFF);
      check("hold_l1_ignores_in", 16'h037D);
      step(1'b1, 3'd3, 16'h0000);
      check("hold_inv3", 16'h037D);
      step(1'b1, 3'd2, 16'h8000);
      check("hold_l2", 16'h04BB);

      // Hand sequence: layer 2 is linear, so negative results survive.
      step(1'b1, 3'd0, 16'h0100);   // h0 = 2.0 + 1.0 = 3.0
      check("lin_l0", 16'h0300);
      step(1'b1, 3'd1, 16'h0000);   // h1 = -1.5 + 4.0 = 2.5
      check("lin_l1", 16'h0280);
      step(1'b1, 3'd2, 16'h0000);   // 2.5 * 1.5 - 0.5 = 3.25
      check("lin_l2", 16'h0340);

      // Randomized run against the reference model.
      step(1'b0, 3'd0, 16'h0000);
      model_step(1'b0, 3'd0, 16'h0000);
      check("rand_reset", mout);
      for (int i = 0; i < 400; i++) begin
         logic        r;
         logic [2:0]  l;
         logic [15:0] d;
         r = ($urandom_range(0, 19) != 0);
         l = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7))
                                          : 3'($urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0:       d = 16'($urandom_range(0, 65535));
            1:       d = 16'($urandom_range(0, 1023));
            2:       d = 16'(16'hFC00 + 16'($urandom_range(0, 1023)));
            default: d = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
         endcase
         step(r, l, d);
         model_step(r, l, d);
         check("random", mout);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
